sysbus_arbiter: RTL and testbench
=================================

Name: sysbus_arbiter

Overview:
- Shares the single Sysbus master port between the instruction-fetch unit (I port) and the load/store unit (D port).
- Allows one transaction in flight. Sequences each transaction: address phase, then read-response beats or write-data beats.
- Routes acks and responses back to the requester that owns the bus.
- Sits between the Core fetch/memory logic and the top-level Sysbus.

Parameters:
- ADDR_W, 64, width of req/resp data and address.
- TAG_W, 13, Sysbus tag width. Bit [TAG_W-1] set = READ, clear = WRITE.
- BEATS, 8, 64-bit beats per cache-line transfer.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- i_reqcyc  in  1  I-port request valid.
- i_req  in  ADDR_W  I-port address.
- i_reqtag  in  TAG_W  I-port tag. Always READ.
- i_reqack  out  1  I-port address accepted.
- i_respcyc  out  1  I-port response beat valid.
- i_resp  out  ADDR_W  I-port response data.
- i_respack  in  1  I-port accepts beat.
- d_reqcyc  in  1  D-port request/data valid.
- d_req  in  ADDR_W  D-port address, then write data.
- d_reqtag  in  TAG_W  D-port tag.
- d_reqack  out  1  D-port address/data beat accepted.
- d_respcyc  out  1  D-port response beat valid.
- d_resp  out  ADDR_W  D-port response data.
- d_respack  in  1  D-port accepts beat.
- bus_reqcyc  out  1  Sysbus request valid.
- bus_req  out  ADDR_W  Sysbus request address/data.
- bus_reqtag  out  TAG_W  Sysbus tag.
- bus_reqack  in  1  Sysbus accepted current req beat.
- bus_respcyc  in  1  Sysbus response beat valid.
- bus_resp  in  ADDR_W  Sysbus response data.
- bus_respack  out  1  response beat accepted.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Reset:
  - reset low forces state=IDLE, owner=I, beat_cnt=0, last_grant=I.
  - All outputs are 0 while reset is low.
  - Reset mid-transaction abandons it; no ack or resp is issued afterwards.
- States: IDLE, ADDR, WDATA, RESP.
- Arbitration, in IDLE only:
  - Sample i_reqcyc/d_reqcyc. If either is high, register owner and go to ADDR next cycle.
  - If both are high, D wins (fixed priority).
  - No grant changes until the transaction returns to IDLE. Minimum one-cycle IDLE gap between transactions.
- ADDR state:
  - bus_reqcyc/bus_req/bus_reqtag = owner's reqcyc/req/reqtag (combinational mux).
  - owner reqack = bus_reqack. Non-owner reqack = 0.
  - Requester holds signals stable until its reqack.
  - On bus_reqack: READ tag -> RESP; WRITE tag -> WDATA. beat_cnt cleared.
  - If the owner drops reqcyc before ack, this is a protocol violation: assertion fires, state is unchanged.
- WDATA state:
  - Same pass-through as ADDR; owner presents one data beat per reqack.
  - Each bus_reqack increments beat_cnt. At beat_cnt==BEATS-1 with ack, go to IDLE.
  - No response phase for writes.
- RESP state:
  - Owner respcyc = bus_respcyc; owner resp = bus_resp; bus_respack = owner respack.
  - Non-owner respcyc = 0, resp = 0.
  - beat_cnt increments on bus_respcyc && bus_respack. At beat_cnt==BEATS-1 with handshake, go to IDLE.
  - A beat with respack low is held and not counted.
- bus_respack is 0 outside RESP. bus_respcyc outside RESP is a protocol violation: assertion fires.
- Outputs:
  - bus_reqcyc is 0 in IDLE and RESP.
  - busy = (state != IDLE).
- beat_cnt: width $clog2(BEATS), wraps to 0 on transaction end.
- Latency: request seen in IDLE at cycle N -> bus_reqcyc at N+1.

Optional Feature:
- Macro: SYSBUS_ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous I and D requests in IDLE, grant the port that is not last_grant.
  - last_grant updates at every grant.
  - Guarantees each port waits at most one transaction.
- Undefined: fixed priority D > I; last_grant register is not built.

Test Plan:
- I read alone: i_reqcyc=1, i_req=0x1000, tag READ; bus acks 2 cycles later and returns 8 beats 0x10..0x17.
  - Required: bus_req=0x1000; i_reqack pulses once; i_resp sees 0x10..0x17 in order; d_respcyc stays 0; busy falls the cycle after beat 8.
- D write: d_req=0x2000, tag WRITE, then data 0xA0..0xA7.
  - Required: 9 d_reqack pulses total; bus_req carries address then data in order; no RESP state entered; returns to IDLE.
- Simultaneous I (0x3000) and D (0x4000) requests, fixed priority.
  - Required: bus_req=0x4000 first; I granted after D completes; i_reqack stays 0 during D's transaction.
- Backpressure: i_respack low for 3 cycles on beat 4.
  - Required: bus_respack low on those cycles; beat 4 delivered exactly once; total 8 counted.
- Reset asserted (reset=0) during beat 5 of a read.
  - Required: all outputs 0 immediately; after release, state IDLE; a new D request is granted normally.
- With SYSBUS_ARB_ROUND_ROBIN_EN defined, both ports requesting continuously for 4 transactions.
  - Required: grant order D, I, D, I.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares the single Sysbus master port between the I (fetch) and D (load/store) ports.
// Define SYSBUS_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests instead of D > I priority.
//
// state | meaning
// IDLE  | no transaction in flight; arbitrate between I and D
// ADDR  | owner's address beat passed through to the bus
// WDATA | owner's write-data beats passed through to the bus
// RESP  | bus read-response beats routed back to the owner
module sysbus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_reqcyc,
    input  logic [ADDR_W-1:0] i_req,
    input  logic [TAG_W-1:0]  i_reqtag,
    output logic              i_reqack,
    output logic              i_respcyc,
    output logic [ADDR_W-1:0] i_resp,
    input  logic              i_respack,
    input  logic              d_reqcyc,
    input  logic [ADDR_W-1:0] d_req,
    input  logic [TAG_W-1:0]  d_reqtag,
    output logic              d_reqack,
    output logic              d_respcyc,
    output logic [ADDR_W-1:0] d_resp,
    input  logic              d_respack,
    output logic              bus_reqcyc,
    output logic [ADDR_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [ADDR_W-1:0] bus_resp,
    output logic              bus_respack,
    output logic              busy
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} arbState;

    arbState          state, stateNext;
    logic             ownerD, ownerDNext;
    logic [CNT_W-1:0] beatCnt, beatCntNext;
    logic             grantD;

    logic              ownReqcyc;
    logic [ADDR_W-1:0] ownReq;
    logic [TAG_W-1:0]  ownTag;
    logic              ownRespack;

    assign ownReqcyc  = ownerD ? d_reqcyc  : i_reqcyc;
    assign ownReq     = ownerD ? d_req     : i_req;
    assign ownTag     = ownerD ? d_reqtag  : i_reqtag;
    assign ownRespack = ownerD ? d_respack : i_respack;

`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
    logic lastGrantD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lastGrantD <= 1'b0;
        else if (state == IDLE && (i_reqcyc || d_reqcyc))
            lastGrantD <= grantD;
    end

    assign grantD = (i_reqcyc && d_reqcyc) ? !lastGrantD : d_reqcyc;
`else
    assign grantD = d_reqcyc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ownerD  <= 1'b0;
            beatCnt <= '0;
        end else begin
            state   <= stateNext;
            ownerD  <= ownerDNext;
            beatCnt <= beatCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        ownerDNext  = ownerD;
        beatCntNext = beatCnt;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        i_reqack    = 1'b0;
        d_reqack    = 1'b0;
        i_respcyc   = 1'b0;
        i_resp      = '0;
        d_respcyc   = 1'b0;
        d_resp      = '0;
        case (state)
            IDLE: begin
                if (i_reqcyc || d_reqcyc) begin
                    ownerDNext = grantD;
                    stateNext  = ADDR;
                end
            end
            ADDR, WDATA: begin
                bus_reqcyc = ownReqcyc;
                bus_req    = ownReq;
                bus_reqtag = ownTag;
                i_reqack   = !ownerD && bus_reqack;
                d_reqack   = ownerD && bus_reqack;
                // A dropped request leaves the state untouched even if the bus acks.
                if (ownReqcyc && bus_reqack) begin
                    if (state == ADDR) begin
                        beatCntNext = '0;
                        stateNext   = ownTag[TAG_W-1] ? RESP : WDATA;
                    end else if (beatCnt == LAST_BEAT) begin
                        beatCntNext = '0;
                        stateNext   = IDLE;
                    end else begin
                        beatCntNext = beatCnt + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                bus_respack = ownRespack;
                if (ownerD) begin
                    d_respcyc = bus_respcyc;
                    d_resp    = bus_resp;
                end else begin
                    i_respcyc = bus_respcyc;
                    i_resp    = bus_resp;
                end
                if (bus_respcyc && ownRespack) begin
                    if (beatCnt == LAST_BEAT) begin
                        beatCntNext = '0;
                        stateNext   = IDLE;
                    end else begin
                        beatCntNext = beatCnt + CNT_W'(1);
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Requester protocol: hold the address beat until acked; the bus answers only in RESP.
    assert property (@(posedge clk) disable iff (!reset) (state == ADDR) |-> ownReqcyc);
    assert property (@(posedge clk) disable iff (!reset) (state != RESP) |-> !bus_respcyc);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed and randomized transactions checked against a queue/rule-based model.
// Honors SYSBUS_ARB_ROUND_ROBIN_EN for the expected grant order.
module tb_sysbus_arbiter;
    localparam int ADDR_W = 64;
    localparam int TAG_W  = 13;
    localparam int BEATS  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_reqcyc, i_reqack, i_respcyc, i_respack;
    logic [ADDR_W-1:0] i_req, i_resp;
    logic [TAG_W-1:0]  i_reqtag;
    logic              d_reqcyc, d_reqack, d_respcyc, d_respack;
    logic [ADDR_W-1:0] d_req, d_resp;
    logic [TAG_W-1:0]  d_reqtag;
    logic              bus_reqcyc, bus_reqack, bus_respcyc, bus_respack, busy;
    logic [ADDR_W-1:0] bus_req, bus_resp;
    logic [TAG_W-1:0]  bus_reqtag;

    sysbus_arbiter #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_reqack(i_reqack),
        .i_respcyc(i_respcyc), .i_resp(i_resp), .i_respack(i_respack),
        .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqack(d_reqack),
        .d_respcyc(d_respcyc), .d_resp(d_resp), .d_respack(d_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_respack(bus_respack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;
    int iAckCnt = 0;
    int dAckCnt = 0;

    // Requester model: one outstanding request per port, held until granted.
    bit                pendI = 1'b0, pendD = 1'b0;
    logic [ADDR_W-1:0] addrI = '0, addrD = '0;
    logic [TAG_W-1:0]  tagI = '0, tagD = '0;
    bit                modelLastD = 1'b0;

    task automatic check1(input string name, input logic obs, input logic exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: got %b expected %b", name, obs, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic checkInt(input string name, input int obs, input int exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: got %0d expected %0d", name, obs, exp);
        end
    endtask

    // Grant rule: a lone requester wins; on a tie D wins, or the port not granted last in round-robin.
    function automatic bit pickD(input bit reqI, input bit reqD, input bit lastD);
        if (reqI && reqD) begin
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
            return !lastD;
`else
            return 1'b1;
`endif
        end
        return reqD;
    endfunction

    task automatic zeroInputs();
        i_reqcyc = 1'b0; i_req = '0; i_reqtag = '0; i_respack = 1'b0;
        d_reqcyc = 1'b0; d_req = '0; d_reqtag = '0; d_respack = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
    endtask

    task automatic driveReqs();
        i_reqcyc = pendI; i_req = addrI; i_reqtag = tagI;
        d_reqcyc = pendD; d_req = addrD; d_reqtag = tagD;
    endtask

    task automatic checkAllZero(input string name);
        check1({name, "_busy"}, busy, 1'b0);
        check1({name, "_bus_reqcyc"}, bus_reqcyc, 1'b0);
        check64({name, "_bus_req"}, bus_req, 64'd0);
        check64({name, "_bus_reqtag"}, 64'(bus_reqtag), 64'd0);
        check1({name, "_bus_respack"}, bus_respack, 1'b0);
        check1({name, "_i_reqack"}, i_reqack, 1'b0);
        check1({name, "_d_reqack"}, d_reqack, 1'b0);
        check1({name, "_i_respcyc"}, i_respcyc, 1'b0);
        check1({name, "_d_respcyc"}, d_respcyc, 1'b0);
        check64({name, "_i_resp"}, i_resp, 64'd0);
        check64({name, "_d_resp"}, d_resp, 64'd0);
    endtask

    task automatic newI();
        pendI = 1'b1;
        addrI = {8'hA1, 24'($urandom), $urandom};
        tagI  = {1'b1, 12'($urandom)};
    endtask

    task automatic newD();
        pendD = 1'b1;
        addrD = {8'hD0, 24'($urandom), $urandom};
        tagD  = {1'($urandom), 12'($urandom)};
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        zeroInputs();
        pendI = 1'b0; pendD = 1'b0; modelLastD = 1'b0;
        #1;
        checkAllZero("reset_held");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check1("reset_release_busy", busy, 1'b0);
    endtask

    task automatic idleStep(input string name);
        @(negedge clk);
        driveReqs();
        bus_reqack = 1'b0; bus_respcyc = 1'b0; i_respack = 1'b0; d_respack = 1'b0;
        #1;
        check1({name, "_busy"}, busy, 1'b0);
        check1({name, "_bus_reqcyc"}, bus_reqcyc, 1'b0);
        check1({name, "_i_respcyc"}, i_respcyc, 1'b0);
        check1({name, "_d_respcyc"}, d_respcyc, 1'b0);
    endtask

    task automatic grantStep(output bit gotD);
        @(negedge clk);
        driveReqs();
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; i_respack = 1'b0; d_respack = 1'b0;
        #1;
        check1("idle_busy", busy, 1'b0);
        check1("idle_bus_reqcyc", bus_reqcyc, 1'b0);
        check1("idle_i_reqack", i_reqack, 1'b0);
        check1("idle_d_reqack", d_reqack, 1'b0);
        check1("idle_bus_respack", bus_respack, 1'b0);
        gotD = pickD(pendI, pendD, modelLastD);
        modelLastD = gotD;
    endtask

    task automatic addrPhase(input bit isD, input int ackDelay, output bit obsD);
        logic [ADDR_W-1:0] a;
        logic [TAG_W-1:0]  t;
        a = isD ? addrD : addrI;
        t = isD ? tagD : tagI;
        obsD = 1'b0;
        for (int c = 0; c <= ackDelay; c++) begin
            @(negedge clk);
            bus_reqack = (c == ackDelay);
            #1;
            if (c == 0) obsD = (bus_req === addrD);
            check1("addr_busy", busy, 1'b1);
            check1("addr_bus_reqcyc", bus_reqcyc, 1'b1);
            check64("addr_bus_req", bus_req, a);
            check64("addr_bus_reqtag", 64'(bus_reqtag), 64'(t));
            check1("addr_i_reqack", i_reqack, !isD && bus_reqack);
            check1("addr_d_reqack", d_reqack, isD && bus_reqack);
            check1("addr_bus_respack", bus_respack, 1'b0);
            if (i_reqack) iAckCnt++;
            if (d_reqack) dAckCnt++;
        end
    endtask

    task automatic writeData(input bit directed);
        logic [ADDR_W-1:0] data [BEATS];
        int b = 0;
        int stall = 0;
        for (int k = 0; k < BEATS; k++)
            data[k] = directed ? 64'hA0 + 64'(k) : {$urandom, $urandom};
        while (b < BEATS) begin
            @(negedge clk);
            d_reqcyc = 1'b1; d_req = data[b]; d_reqtag = tagD;
            bus_reqack = directed || (stall >= 2) || ($urandom_range(0, 2) == 0);
            #1;
            check1("wr_busy", busy, 1'b1);
            check1("wr_bus_reqcyc", bus_reqcyc, 1'b1);
            check64("wr_bus_req", bus_req, data[b]);
            check1("wr_d_reqack", d_reqack, bus_reqack);
            check1("wr_i_reqack", i_reqack, 1'b0);
            check1("wr_bus_respack", bus_respack, 1'b0);
            check1("wr_d_respcyc", d_respcyc, 1'b0);
            if (d_reqack) dAckCnt++;
            if (bus_reqack) begin
                b++;
                stall = 0;
            end else begin
                stall++;
            end
        end
    endtask

    task automatic readResp(input bit isD, input bit directed, input int stallBeat, input int stallLen,
                            input int resetBeat);
        logic [ADDR_W-1:0] data [BEATS];
        int b = 0;
        int held = 0;
        int delivered = 0;
        bit ack, gap;
        for (int k = 0; k < BEATS; k++)
            data[k] = directed ? 64'h10 + 64'(k) : {$urandom, $urandom};
        while (b < BEATS) begin
            @(negedge clk);
            driveReqs();
            bus_reqack = 1'b0;
            gap = !directed && ($urandom_range(0, 3) == 0);
            bus_respcyc = !gap;
            bus_resp = data[b];
            ack = !(b == stallBeat && held < stallLen);
            if (isD) begin
                d_respack = ack; i_respack = !ack;
            end else begin
                i_respack = ack; d_respack = !ack;
            end
            if (b == resetBeat) begin
                reset = 1'b0;
                #1;
                checkAllZero("reset_mid");
                return;
            end
            #1;
            check1("resp_busy", busy, 1'b1);
            check1("resp_bus_reqcyc", bus_reqcyc, 1'b0);
            check1("resp_bus_respack", bus_respack, ack);
            check1("resp_own_respcyc", isD ? d_respcyc : i_respcyc, !gap);
            if (!gap) check64("resp_own_data", isD ? d_resp : i_resp, data[b]);
            check1("resp_other_respcyc", isD ? i_respcyc : d_respcyc, 1'b0);
            check64("resp_other_data", isD ? i_resp : d_resp, 64'd0);
            if ((isD ? d_respcyc : i_respcyc) && bus_respack) delivered++;
            if (!gap) begin
                if (ack) b++;
                else held++;
            end
        end
        checkInt("resp_delivered", delivered, BEATS);
    endtask

    task automatic runOne(input int ackDelay, input int stallBeat, input int stallLen, input bit directed,
                          output bit gotD, output bit obsD);
        bit isRead;
        grantStep(gotD);
        isRead = gotD ? tagD[TAG_W-1] : tagI[TAG_W-1];
        addrPhase(gotD, ackDelay, obsD);
        if (gotD) pendD = 1'b0;
        else pendI = 1'b0;
        if (isRead) readResp(gotD, directed, stallBeat, stallLen, -1);
        else writeData(directed);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit gotD, obsD;
        bit expOrder [4];
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
        expOrder = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        expOrder = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        zeroInputs();
        i_reqcyc = 1'b1; d_reqcyc = 1'b1; i_req = 64'h55; d_req = 64'h66;
        @(negedge clk);
        #1;
        checkAllZero("por");
        @(negedge clk);
        zeroInputs();
        reset = 1'b1;
        #1;
        check1("por_release_busy", busy, 1'b0);

        // I read alone, bus acks two cycles late, data 0x10..0x17
        pendI = 1'b1; addrI = 64'h1000; tagI = 13'h1000; iAckCnt = 0;
        runOne(2, -1, 0, 1'b1, gotD, obsD);
        checkInt("i_read_reqack_pulses", iAckCnt, 1);
        idleStep("i_read_done");

        // D write: address then data 0xA0..0xA7
        pendD = 1'b1; addrD = 64'h2000; tagD = 13'h0001; dAckCnt = 0;
        runOne(1, -1, 0, 1'b1, gotD, obsD);
        checkInt("d_write_reqack_pulses", dAckCnt, 9);
        idleStep("d_write_done");

        // Simultaneous I and D, then the loser follows
        doReset();
        pendI = 1'b1; addrI = 64'h3000; tagI = 13'h1000;
        pendD = 1'b1; addrD = 64'h4000; tagD = 13'h1002;
        iAckCnt = 0;
        runOne(0, -1, 0, 1'b1, gotD, obsD);
        check1("simul_first_d", obsD, 1'b1);
        checkInt("simul_i_ack_during_d", iAckCnt, 0);
        runOne(0, -1, 0, 1'b1, gotD, obsD);
        check1("simul_second_i", obsD, 1'b0);
        idleStep("simul_done");

        // Backpressure: I holds beat 4 for three cycles
        pendI = 1'b1; addrI = 64'h5000; tagI = 13'h1000;
        runOne(0, 3, 3, 1'b1, gotD, obsD);
        idleStep("bp_done");

        // Reset during beat 5 of a read, then a fresh D request
        pendI = 1'b1; addrI = 64'h6000; tagI = 13'h1000;
        grantStep(gotD);
        addrPhase(gotD, 1, obsD);
        pendI = 1'b0;
        readResp(gotD, 1'b1, -1, 0, 4);
        doReset();
        idleStep("after_reset");
        pendD = 1'b1; addrD = 64'h7000; tagD = 13'h0003;
        runOne(0, -1, 0, 1'b1, gotD, obsD);
        check1("reset_new_d_granted", obsD, 1'b1);

        // Both ports requesting continuously for four transactions
        doReset();
        newI(); newD();
        for (int t = 0; t < 4; t++) begin
            runOne(int'($urandom_range(0, 2)), -1, 0, 1'b0, gotD, obsD);
            check1("continuous_grant_order", obsD, expOrder[t]);
            if (gotD) newD();
            else newI();
        end

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (!pendI && $urandom_range(0, 1) == 1) newI();
            if (!pendD && $urandom_range(0, 1) == 1) newD();
            if (!pendI && !pendD) newD();
            runOne(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                   1'b0, gotD, obsD);
        end
        while (pendI || pendD)
            runOne(int'($urandom_range(0, 2)), -1, 0, 1'b0, gotD, obsD);
        idleStep("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
